// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hold/flush sequencer for the 5-stage pipeline.
// Resolves load-use stalls, taken-branch squashes, data-memory waits and
// SYSCALL halt/resume, and keeps saturating performance counters.

// Saturating up-counter; one instance per performance counter.
module pipeline_hazard_ctrl_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Clear on reset, otherwise count up and stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (inc && ~&cnt)    cnt <= cnt + W'(1);
  end

endmodule

module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [4:0]       id_rs_num,
  input  logic [4:0]       id_rt_num,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             ex_memtoreg,
  input  logic             ex_regwrite,
  input  logic [4:0]       ex_w_num,
  input  logic             ex_branch_taken,
  input  logic             mem_wait,
  input  logic             wb_halt,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             id_ex_hold,
  output logic             ex_mem_hold,
  output logic             mem_wb_hold,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } hold_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } flush_t;

  localparam int NCNT = 3;
  localparam int CYC  = 0;
  localparam int STL  = 1;
  localparam int FLS  = 2;

  state_t                      state_q, state_d;
  hold_t                       hold;
  flush_t                      flush;
  logic                        lu;
  logic                        stall_inc, flush_inc;
  logic [NCNT-1:0]             cnt_inc;
  logic [NCNT-1:0][CNT_W-1:0]  cnt_q;

  // Load in EX whose destination is a live source of the ID instruction.
  assign lu = ex_memtoreg && ex_regwrite && (ex_w_num != 5'd0) &&
              ((id_rs_used && (id_rs_num == ex_w_num)) ||
               (id_rt_used && (id_rt_num == ex_w_num)));

  // Run/halt state register; reset always lands in RUN.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state and same-cycle hold/flush controls, highest priority first.
  always_comb begin
    state_d   = state_q;
    hold      = '0;
    flush     = '0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (rst) begin
      flush = '1;
    end else if (state_q == HALT) begin
      hold = '1;
      if (go) state_d = RUN;
    end else if (wb_halt) begin
      // Freeze the front of the pipe; the SYSCALL itself leaves WB as a bubble.
      hold         = '{pc: 1'b1, if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b0};
      flush.mem_wb = 1'b1;
      state_d      = HALT;
    end else if (mem_wait) begin
      hold         = '{pc: 1'b1, if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b0};
      flush.mem_wb = 1'b1;
      stall_inc    = 1'b1;
    end else if (ex_branch_taken) begin
      // Squash the two wrong-path instructions; the hazard they carry dies with them.
      flush.if_id = 1'b1;
      flush.id_ex = 1'b1;
      flush_inc   = 1'b1;
    end else if (lu) begin
      // One bubble: by next cycle the load sits in MEM and forwarding covers it.
      hold.pc     = 1'b1;
      hold.if_id  = 1'b1;
      flush.id_ex = 1'b1;
      stall_inc   = 1'b1;
    end
  end

  assign cnt_inc[CYC] = !rst && (state_q == RUN);
  assign cnt_inc[STL] = stall_inc;
  assign cnt_inc[FLS] = flush_inc;

  genvar g;
  generate
    for (g = 0; g < NCNT; g++) begin : g_cnt
      pipeline_hazard_ctrl_sat_cnt #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (cnt_inc[g]),
        .cnt (cnt_q[g])
      );
    end
  endgenerate

  assign pc_hold      = hold.pc;
  assign if_id_hold   = hold.if_id;
  assign id_ex_hold   = hold.id_ex;
  assign ex_mem_hold  = hold.ex_mem;
  assign mem_wb_hold  = hold.mem_wb;
  assign if_id_flush  = flush.if_id;
  assign id_ex_flush  = flush.id_ex;
  assign ex_mem_flush = flush.ex_mem;
  assign mem_wb_flush = flush.mem_wb;
  assign halted       = (state_q == HALT);
  assign cycle_cnt    = cnt_q[CYC];
  assign stall_cnt    = cnt_q[STL];
  assign flush_cnt    = cnt_q[FLS];

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline. It drives the hold and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch squashes, data-memory wait states and SYSCALL halt/resume, and keeps performance counters for the debug display.

Parameters:
CNT_W, 32, width of cycle_cnt, stall_cnt and flush_cnt.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
go  in  1  resume request, honoured only in HALT
id_rs_num  in  5  rs field of the instruction in ID
id_rt_num  in  5  rt field of the instruction in ID
id_rs_used  in  1  ID instruction reads rs
id_rt_used  in  1  ID instruction reads rt
ex_memtoreg  in  1  EX instruction is a load
ex_regwrite  in  1  EX instruction writes the register file
ex_w_num  in  5  destination register of the EX instruction
ex_branch_taken  in  1  branch/jump resolved taken in EX
mem_wait  in  1  data memory not ready this cycle
wb_halt  in  1  SYSCALL with halt code is in WB
pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_hold  out  1 each  1 = register keeps its value (hold beats flush)
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  1 = register clears to a bubble at the next edge
halted  out  1  registered, 1 while in HALT
cycle_cnt, stall_cnt, flush_cnt  out  CNT_W each  registered counters

Behaviour:
- State register with two states: RUN and HALT. Reset enters RUN and clears all three counters to 0. halted=0 after reset.
- Hold and flush outputs are combinational from the current state and the inputs, so they take effect at the same edge.
- When rst=1: all flushes=1 and all holds=0, whatever the state or inputs.
- Load-use hazard (lu) = ex_memtoreg & ex_regwrite & ex_w_num≠0 & ((id_rs_used & id_rs_num==ex_w_num) | (id_rt_used & id_rt_num==ex_w_num)).
- RUN priority, highest first; an output not listed for a case is 0:
  1. wb_halt: pc/if_id/id_ex/ex_mem hold=1, mem_wb_flush=1. Next state HALT.
  2. mem_wait: pc/if_id/id_ex/ex_mem hold=1, mem_wb_flush=1. stall_cnt+1.
  3. ex_branch_taken: if_id_flush=1, id_ex_flush=1, no holds (PC loads the target). flush_cnt+1. lu is ignored in this case.
  4. lu: pc_hold=1, if_id_hold=1, id_ex_flush=1. stall_cnt+1. Exactly 1 bubble per hazard; lu clears once the load moves to MEM.
  5. None of the above: all holds and flushes 0.
- HALT: all five holds=1 and all flushes=0. All other inputs are ignored.
  - go=1 → RUN at the next edge; the first RUN cycle applies normal rules.
  - The halting SYSCALL was already flushed from WB, so it cannot re-trigger.
- cycle_cnt increments on every RUN cycle (including stall and flush cycles), not in HALT, and not in the rst cycle.
- All counters saturate at 2^CNT_W−1 and do not wrap.
- rst asserted mid-stall or in HALT: state returns to RUN and counters clear at that edge.

Test Plan:
1. Load-use: lw $8 in EX (ex_memtoreg=1, ex_regwrite=1, ex_w_num=8), ID reads rs=8 with id_rs_used=1 → pc_hold=1, if_id_hold=1, id_ex_flush=1 for exactly 1 cycle; stall_cnt 0→1.
2. No false hazard: ex_w_num=0, or id_rs_used=0 with rs=8 → all controls 0; stall_cnt unchanged.
3. Branch plus simultaneous load-use: ex_branch_taken=1 with lu true → if_id_flush=1, id_ex_flush=1, pc_hold=0; flush_cnt+1; stall_cnt unchanged.
4. mem_wait held for 3 cycles → pc..ex_mem hold=1 and mem_wb_flush=1 in each cycle; stall_cnt+3; cycle_cnt+3.
5. Halt/resume: wb_halt=1 for 1 cycle → halted=1 next cycle and all holds=1; cycle_cnt frozen across 10 HALT cycles; go=1 → halted=0 at the next edge and cycle_cnt resumes counting.
6. Reset in HALT with all counters nonzero: rst=1 → all flushes=1, all holds=0; next cycle halted=0 and all counters=0. Saturation check with CNT_W=4: 20 stall cycles → stall_cnt=15.
